// File: rtl/cgra_config_loader_if.sv
// rtl/cgra_config_loader_if.sv - host word stream and readback stream bundle for the config loader
interface cgra_config_loader_if #(
    parameter int WORD_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              rb_valid;
    logic              rb_ready;
    logic [WORD_W-1:0] rb_data;

    modport master (
        output in_valid, in_data, rb_ready,
        input  in_ready, rb_valid, rb_data
    );

    modport slave (
        input  in_valid, in_data, rb_ready,
        output in_ready, rb_valid, rb_data
    );
endinterface

// File: rtl/cgra_config_loader.sv
// rtl/cgra_config_loader.sv - serialises host config words onto the CGRA scan chain and repacks readback
module cgra_config_loader #(
    parameter int WORD_W   = 32,
    parameter int LEN_W    = 16,
    parameter int READBACK = 1
) (
    input  logic             Config_Clock,
    input  logic             Config_Reset,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] len_bits,
    output logic             ConfigSerialOut,
    input  logic             ConfigSerialIn,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    cgra_config_loader_if.slave io
);
    localparam int SH    = $clog2(WORD_W);
    localparam int CNT_W = SH + 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_sent;
    logic [LEN_W-1:0]  r_loaded;      // chain bits already moved into shreg
    logic [LEN_W:0]    r_words_left;  // host words still to be accepted this load
    logic [WORD_W-1:0] r_buf;
    logic              r_buf_full;
    logic [WORD_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_sh_cnt;      // valid bits left in shreg
    logic [WORD_W-1:0] r_rb_sh;
    logic [CNT_W-1:0]  r_rb_cnt;
    logic [WORD_W-1:0] r_rb_hold;
    logic              r_rb_valid;

    logic              w_rb_free;
    logic              w_shift;
    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_sh_empty_next;
    logic [LEN_W-1:0]  w_remain;
    logic [CNT_W-1:0]  w_load_cnt;
    logic [WORD_W-1:0] w_rb_next;
    logic              w_rb_last;
    logic [WORD_W-1:0] w_rb_word;
    logic [LEN_W:0]    w_words_init;

    // Readback taken this cycle counts as free so word boundaries cost no bubble.
    assign w_rb_free       = (READBACK == 0) || !r_rb_valid || io.rb_ready;
    assign w_shift         = (r_state == S_SHIFT) && (r_sh_cnt != '0) && (r_sent < r_len) && w_rb_free;
    assign w_in_ready      = (r_state != S_IDLE) && !r_buf_full && (r_words_left != '0);
    assign w_in_fire       = io.in_valid && w_in_ready;
    // shreg refills on the cycle its last bit leaves, keeping back-to-back words contiguous.
    assign w_sh_empty_next = (r_sh_cnt == '0) || ((r_sh_cnt == CNT_W'(1)) && w_shift);
    // The final word only contributes the bits still owed to the chain.
    assign w_remain        = r_len - r_loaded;
    assign w_load_cnt      = (w_remain >= LEN_W'(WORD_W)) ? CNT_W'(WORD_W) : w_remain[CNT_W-1:0];
    assign w_rb_next       = {ConfigSerialIn, r_rb_sh[WORD_W-1:1]};
    assign w_rb_last       = (r_rb_cnt == CNT_W'(WORD_W-1)) || ((r_sent + LEN_W'(1)) == r_len);
    // A short final readback word is shifted down so its first bit lands in bit 0.
    assign w_rb_word       = w_rb_next >> (CNT_W'(WORD_W-1) - r_rb_cnt);
    assign w_words_init    = ({1'b0, len_bits} + (LEN_W+1)'(WORD_W-1)) >> SH;

    assign shift_en        = w_shift;
    assign ConfigSerialOut = w_shift & r_shreg[0];
    assign busy            = (r_state != S_IDLE);
    assign done            = (r_state == S_DONE);
    assign io.in_ready     = w_in_ready;
    assign io.rb_valid     = r_rb_valid;
    assign io.rb_data      = r_rb_hold;

    // Load sequencing, word intake, serialisation and readback packing.
    always_ff @(posedge Config_Clock) begin
        if (Config_Reset || abort) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_sent       <= '0;
            r_loaded     <= '0;
            r_words_left <= '0;
            r_buf        <= '0;
            r_buf_full   <= 1'b0;
            r_shreg      <= '0;
            r_sh_cnt     <= '0;
            r_rb_sh      <= '0;
            r_rb_cnt     <= '0;
            r_rb_hold    <= '0;
            r_rb_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len        <= len_bits;
                        r_sent       <= '0;
                        r_loaded     <= '0;
                        r_words_left <= w_words_init;
                        r_buf_full   <= 1'b0;
                        r_sh_cnt     <= '0;
                        r_rb_sh      <= '0;
                        r_rb_cnt     <= '0;
                        r_state      <= (len_bits == '0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_shift && ((r_sent + LEN_W'(1)) == r_len)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((READBACK == 0) || !r_rb_valid || io.rb_ready) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (w_in_fire) begin
                r_words_left <= r_words_left - (LEN_W+1)'(1);
            end

            if (w_sh_empty_next && r_buf_full) begin
                r_shreg    <= r_buf;
                r_sh_cnt   <= w_load_cnt;
                r_loaded   <= r_loaded + LEN_W'(w_load_cnt);
                r_buf_full <= 1'b0;
            end else if (w_sh_empty_next && w_in_fire) begin
                r_shreg  <= io.in_data;
                r_sh_cnt <= w_load_cnt;
                r_loaded <= r_loaded + LEN_W'(w_load_cnt);
            end else begin
                if (w_in_fire) begin
                    r_buf      <= io.in_data;
                    r_buf_full <= 1'b1;
                end
                if (w_shift) begin
                    r_shreg  <= r_shreg >> 1;
                    r_sh_cnt <= r_sh_cnt - CNT_W'(1);
                end
            end

            if (r_rb_valid && io.rb_ready) begin
                r_rb_valid <= 1'b0;
            end

            if (w_shift) begin
                r_sent <= r_sent + LEN_W'(1);
                if (w_rb_last) begin
                    r_rb_hold  <= w_rb_word;
                    r_rb_valid <= (READBACK != 0);
                    r_rb_sh    <= '0;
                    r_rb_cnt   <= '0;
                end else begin
                    r_rb_sh  <= w_rb_next;
                    r_rb_cnt <= r_rb_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule
